fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the CPU datapath.
- Holds the 8-bit program counter and reads opcodes from a synchronous program memory with 1-cycle read latency.
- Issues each opcode onto the opcode bus with a one-cycle valid strobe, then advances the PC or loads a jump target from the condition unit.
- Supports free-run, pause and single-step control, plus a halt opcode.

Parameters:
ADDR_W, 8, program counter / memory address width
DATA_W, 8, opcode width
RESET_PC, 0, PC value after reset
HALT_OP, 8'hFF, opcode value that stops fetching

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
run  input  1  1 = free-run, 0 = pause after the current instruction
step  input  1  single-step request; rising edge detected internally, honoured only while paused
mem_rd  output  1  program memory read strobe
mem_addr  output  ADDR_W  program memory address
mem_data  input  DATA_W  read data, valid the cycle after mem_rd
jump_take  input  1  condition unit result (condition decode AND judgeVal)
jump_target  input  ADDR_W  jump destination (reg0 value)
opcode  output  DATA_W  current opcode bus, held between issues
opcode_valid  output  1  one-cycle strobe: the datapath executes opcode this cycle
pc  output  ADDR_W  address of the current/next instruction
halted  output  1  high once HALT_OP has been fetched
retire_count  output  16  number of issued instructions, wraps at 0xFFFF -> 0

Behaviour:
- Reset is synchronous and active-low, evaluated on the rising clk edge, with priority over everything. After reset:
  - state=IDLE, pc=RESET_PC
  - opcode=0, opcode_valid=0, mem_rd=0, mem_addr=RESET_PC
  - halted=0, retire_count=0
  - step edge register cleared
- Reset mid-fetch abandons the instruction. No strobe is issued and the PC is not advanced.
- mem_addr = pc combinationally in all states.
- States: IDLE, FETCH, WAIT, ISSUE, HALT.
- IDLE:
  - Go to FETCH if run=1.
  - Go to FETCH and set the internal single flag if run=0 and a step rising edge is seen (step=1 with previous step=0).
  - Otherwise stay in IDLE.
- FETCH: mem_rd=1, next state WAIT.
- WAIT:
  - mem_data is valid this cycle.
  - If mem_data==HALT_OP: go to HALT, set halted=1, leave opcode unchanged, no strobe.
  - Otherwise: opcode<=mem_data, next state ISSUE.
- ISSUE: opcode_valid=1, retire_count increments by 1, and on the clock edge:
  - jump_take=1 -> pc<=jump_target
  - jump_take=0 -> pc<=pc+1 (modulo 2^ADDR_W, so 0xFF -> 0x00)
  - Next state FETCH if run=1 and the single flag is clear; otherwise IDLE (the single flag is cleared).
- jump_take and jump_target are sampled only in ISSUE and ignored in every other state.
- HALT:
  - Absorbing; only rst_n=0 leaves it.
  - pc stays at the halt instruction's address.
  - mem_rd=0, opcode_valid=0.
- Throughput in run mode: one instruction per 3 cycles (FETCH, WAIT, ISSUE). opcode_valid is never high on two consecutive cycles.
- Dropping run mid-instruction (FETCH/WAIT/ISSUE) lets the instruction complete and issue, then the unit stops in IDLE.
- step edges while run=1 are ignored. step edges outside IDLE are ignored, not queued.
- A held step level produces exactly one instruction.
- Simultaneous run=1 and a step edge in IDLE behaves as run.
- opcode holds its last issued value in IDLE and HALT.

Test Plan:
- Reset with run=1, memory [0]=0x11, [1]=0x22, [2]=0x33 -> strobes at cycles 3, 6, 9 after reset release; opcode 0x11, 0x22, 0x33; pc 1, 2, 3; retire_count=3.
- Jump: [0]=0xC4 with jump_take=1 and jump_target=0x40 during ISSUE -> next mem_addr=0x40 in FETCH; same case with jump_take=0 -> next mem_addr=0x01.
- Wrap: RESET_PC=0xFE, run=1, no jumps -> pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Single-step: run=0, step held high 20 cycles -> exactly one strobe, pc=1, state returns to IDLE; a second 0->1 step edge -> pc=2.
- Pause and halt: run drops during WAIT of [1] -> [1] still issues, then IDLE with pc=2. Separately, [3]=0xFF with run=1 -> three strobes, halted=1, pc=3, no further mem_rd for 50 cycles; rst_n low for 1 cycle -> pc=0, halted=0.
- Reset mid-operation: rst_n=0 during WAIT -> no strobe, pc=RESET_PC, opcode=0, retire_count=0 on the next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage: PC, synchronous program memory read,
//            one-cycle opcode issue strobe, jump load, run/pause/step, halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] HALT_OP  = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              jump_take,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [DATA_W-1:0] opcode,
  output logic              opcode_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       retire_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_opcode;
  logic              r_opcode_valid;
  logic              r_mem_rd;
  logic              r_halted;
  logic [15:0]       r_retire;
  logic              r_step_prev;
  logic              r_single;
  logic              w_step_edge;

  assign w_step_edge = step & ~r_step_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_opcode       <= '0;
      r_opcode_valid <= 1'b0;
      r_mem_rd       <= 1'b0;
      r_halted       <= 1'b0;
      r_retire       <= '0;
      r_step_prev    <= 1'b0;
      r_single       <= 1'b0;
    end else begin
      r_step_prev    <= step;
      r_mem_rd       <= 1'b0;
      r_opcode_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // run takes priority; a step edge only counts while paused
          if (run) begin
            r_state  <= S_FETCH;
            r_mem_rd <= 1'b1;
          end else if (w_step_edge) begin
            r_state  <= S_FETCH;
            r_mem_rd <= 1'b1;
            r_single <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (mem_data == HALT_OP) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_opcode       <= mem_data;
            r_opcode_valid <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_retire <= r_retire + 16'd1;
          r_pc     <= jump_take ? jump_target : r_pc + 1'b1;
          r_single <= 1'b0;
          if (run && !r_single) begin
            r_state  <= S_FETCH;
            r_mem_rd <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr     = r_pc;
  assign mem_rd       = r_mem_rd;
  assign opcode       = r_opcode;
  assign opcode_valid = r_opcode_valid;
  assign pc           = r_pc;
  assign halted       = r_halted;
  assign retire_count = r_retire;

endmodule

`default_nettype wire
